// File: rtl/reg_file_sb.sv
// Integer register file, 2 read / 1 write, with a post-reset clear sequencer,
// optional write-to-read bypass and a per-register busy scoreboard.
module reg_file_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  input  logic [AW-1:0]   A3,
  input  logic            WE3,
  input  logic [XLEN-1:0] WD3,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  output logic            busy1,
  output logic            busy2,
  output logic            ready
);

  localparam int unsigned NumAddr = 1 << AW;

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e              state_q;
  logic [AW-1:0]       clr_ptr_q;
  logic                ready_q;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0]     regs_q [NUM_REGS];

  // Constant map of addresses that name a real, writable register (excludes x0).
  logic [NumAddr-1:0] addr_ok;
  always_comb begin
    addr_ok = '0;
    for (int i = 0; i < int'(NumAddr); i++) begin
      addr_ok[i] = (i != 0) && (i < int'(NUM_REGS));
    end
  end

  logic run, wr_ok, rsv_ok, hit1, hit2;
  assign run    = (state_q == StRun);
  assign wr_ok  = WE3 && addr_ok[A3];
  assign rsv_ok = rsv_en && addr_ok[rsv_addr];
  assign hit1   = BYPASS && wr_ok && (A3 == A1);
  assign hit2   = BYPASS && wr_ok && (A3 == A2);

  always_comb begin
    RD1   = '0;
    RD2   = '0;
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (run && addr_ok[A1]) begin
      RD1   = hit1 ? WD3 : regs_q[A1];
      busy1 = busy_q[A1] && !hit1;
    end
    if (run && addr_ok[A2]) begin
      RD2   = hit2 ? WD3 : regs_q[A2];
      busy2 = busy_q[A2] && !hit2;
    end
  end

  // Reserve is applied after the write clear so a newer producer keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[A3] = 1'b0;
    end
    if (rsv_ok) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StClear;
      clr_ptr_q <= AW'(1);
      ready_q   <= 1'b0;
      busy_q    <= '0;
    end else begin
      unique case (state_q)
        StClear: begin
          if (clr_ptr_q == AW'(NUM_REGS - 1)) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end else begin
            clr_ptr_q <= clr_ptr_q + AW'(1);
          end
        end
        StRun: begin
          busy_q <= busy_d;
        end
        default: begin
          state_q <= StClear;
        end
      endcase
    end
  end

  // Storage has no reset; the clear sequencer zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == StClear) begin
        regs_q[clr_ptr_q] <= '0;
      end else if (wr_ok) begin
        regs_q[A3] <= WD3;
      end
    end
  end

  assign ready = ready_q;

endmodule
